// File: rtl/mult_pkg.sv
// Shared types and limits for the sequential shift-add multiplier.
// Contents: controller state encoding, maximum supported operand width,
// and a helper that sizes the iteration counter.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned MAX_WIDTH = 32;

  // Counter must hold values 0..WIDTH.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_if.sv
// Handshake/bus bundle between the multiplier and its harness.
// master: drives load, a, b; observes busy, done, product.
// slave : the multiplier side.
interface mult_if #(
  parameter int unsigned WIDTH = 8
);

  logic                 load;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output load, a, b, input busy, done, product);
  modport slave  (input load, a, b, output busy, done, product);

endinterface

// File: rtl/mult_ctrl.sv
// Controller for mult_seq: IDLE/RUN/DONE FSM plus iteration counter.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   load              start request, honoured only in IDLE
//   capture           strobe: load accepted this edge (decode of state)
//   step              strobe: one datapath iteration this edge
//   finish            strobe: last iteration this edge, write product
//   busy, done        registered status (busy in RUN/DONE, done in DONE)
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic capture,
  output logic step,
  output logic finish,
  output logic busy,
  output logic done
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state;
  logic [CW-1:0] count;

  // Datapath strobes are pure decodes of the registered state/counter.
  assign capture = (state == IDLE) && load;
  assign step    = (state == RUN);
  assign finish  = step && (count == LAST);

  // FSM, counter and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state <= RUN;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          count <= count + CW'(1);
          if (count == LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier, WIDTH-bit operands, 2*WIDTH-bit product,
// fixed latency of WIDTH iterations.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    mult_if slave: load/a/b in, busy/done/product out
// Build option: define MULT_SIGNED_EN for two's complement operands/product
// (magnitudes multiplied, result negated when the signs differ).
module mult_seq
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic   clk,
  input  logic   reset,
  mult_if.slave  bus
);

  localparam int unsigned PW = 2 * WIDTH;

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("mult_seq: WIDTH out of range");
  end

  logic          capture;
  logic          step;
  logic          finish;
  logic          busy;
  logic          done;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    product;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [PW-1:0]    result;

  mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .load    (bus.load),
    .capture (capture),
    .step    (step),
    .finish  (finish),
    .busy    (busy),
    .done    (done)
  );

`ifdef MULT_SIGNED_EN
  logic sign;

  // Magnitudes; the most-negative value maps to 2^(WIDTH-1), which still fits.
  always_comb begin
    a_in = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
    b_in = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;
  end

  always_comb result = sign ? (~acc_next + PW'(1)) : acc_next;

  always_ff @(posedge clk) begin
    if (reset)        sign <= 1'b0;
    else if (capture) sign <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
  end
`else
  always_comb begin
    a_in = bus.a;
    b_in = bus.b;
  end

  always_comb result = acc_next;
`endif

  // One iteration: add into upper WIDTH+1 bits (bit WIDTH is carry), shift right.
  always_comb begin
    sum      = {1'b0, acc[PW-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_next = PW'({sum, acc[WIDTH-1:0]} >> 1);
  end

  // Operand, accumulator and product registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      product <= '0;
    end else if (capture) begin
      mcand  <= a_in;
      mplier <= b_in;
      acc    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mplier <= mplier >> 1;
      if (finish) product <= result;
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: a WIDTH=8 and a WIDTH=1 instance run side by side
// against a cycle-level arithmetic model, plus literal expectations per op.
module tb_mult_seq;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mult_if #(.WIDTH(8)) bus8 ();
  mult_if #(.WIDTH(1)) bus1 ();

  mult_seq #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  mult_seq #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic        in_ld[2];
  logic [31:0] in_a[2];
  logic [31:0] in_b[2];
  logic        out_busy[2];
  logic        out_done[2];
  logic [63:0] out_p[2];

  assign in_ld[0]    = bus8.load;
  assign in_a[0]     = 32'(bus8.a);
  assign in_b[0]     = 32'(bus8.b);
  assign out_busy[0] = bus8.busy;
  assign out_done[0] = bus8.done;
  assign out_p[0]    = 64'(bus8.product);
  assign in_ld[1]    = bus1.load;
  assign in_a[1]     = 32'(bus1.a);
  assign in_b[1]     = 32'(bus1.b);
  assign out_busy[1] = bus1.busy;
  assign out_done[1] = bus1.done;
  assign out_p[1]    = 64'(bus1.product);

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state: cycle index k is the interval after posedge number k.
  bit          act[2]  = '{0, 0};
  int          t0[2]   = '{0, 0};
  logic [63:0] pend[2] = '{64'd0, 64'd0};
  logic [63:0] prod[2] = '{64'd0, 64'd0};

  function automatic int wdt(input int k);
    return (k == 0) ? 8 : 1;
  endfunction

  // Arithmetic product of two w-bit operands, kept to 2w bits.
  function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] m;
    m = (64'd1 << (2 * w)) - 64'd1;
`ifdef MULT_SIGNED_EN
    sa = a[w-1] ? (longint'(a) - (longint'(1) << w)) : longint'(a);
    sb = b[w-1] ? (longint'(b) - (longint'(1) << w)) : longint'(b);
`else
    sa = longint'(a);
    sb = longint'(b);
`endif
    return 64'(sa * sb) & m;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Model: accepted load at edge T -> busy cycles T..T+W, done at T+W,
  // product visible from T+W, next load accepted no earlier than edge T+W+2.
  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        act[k]  = 1'b0;
        prod[k] = 64'd0;
      end else begin
        if (act[k] && cyc == t0[k] + wdt(k)) prod[k] = pend[k];
        if (act[k] && cyc >= t0[k] + wdt(k) + 2) act[k] = 1'b0;
        if (!act[k] && in_ld[k]) begin
          act[k]  = 1'b1;
          t0[k]   = cyc;
          pend[k] = model(wdt(k), in_a[k], in_b[k]);
        end
      end
    end
  end

  // Compare every cycle, mid-cycle.
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int k = 0; k < 2; k++) begin
        logic eb;
        logic ed;
        eb = act[k] && cyc >= t0[k] && cyc <= t0[k] + wdt(k);
        ed = act[k] && cyc == t0[k] + wdt(k);
        check($sformatf("busy%0d", k), 64'(out_busy[k]), 64'(eb));
        check($sformatf("done%0d", k), 64'(out_done[k]), 64'(ed));
        check($sformatf("product%0d", k), out_p[k], prod[k]);
      end
    end
  end

  task automatic drive(input int k, input logic ld, input logic [31:0] a, input logic [31:0] b);
    if (k == 0) begin
      bus8.load = ld;
      bus8.a    = 8'(a);
      bus8.b    = 8'(b);
    end else begin
      bus1.load = ld;
      bus1.a    = 1'(a);
      bus1.b    = 1'(b);
    end
  endtask

  // Raise load for one edge (or leave it high when hold=1); ledge = accept edge.
  task automatic start(input int k, input logic [31:0] a, input logic [31:0] b,
                       input bit hold, output int ledge);
    @(posedge clk);
    #1 drive(k, 1'b1, a, b);
    @(posedge clk);
    #1 ledge = cyc;
    if (!hold) drive(k, 1'b0, a, b);
  endtask

  task automatic wait_done(input int k, input int ledge, input logic [63:0] lit,
                           input string name, output int dcyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_done[k]) seen = 1'b1;
    end
    dcyc = cyc;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done, required done within 40 cycles", name);
    end else begin
      check({name, "_lat"}, 64'(dcyc - ledge), 64'(wdt(k)));
      check({name, "_prod"}, out_p[k], lit);
    end
  endtask

`ifdef MULT_SIGNED_EN
  localparam int NV = 4;
  logic [31:0] va[NV] = '{32'd13, 32'hFD, 32'h80, 32'd127};
  logic [31:0] vb[NV] = '{32'd11, 32'd5,  32'h80, 32'hFF};
  logic [63:0] vp[NV] = '{64'd143, 64'hFFF1, 64'd16384, 64'hFF81};
`else
  localparam int NV = 3;
  logic [31:0] va[NV] = '{32'd13,  32'd255,   32'd0};
  logic [31:0] vb[NV] = '{32'd11,  32'd255,   32'd200};
  logic [63:0] vp[NV] = '{64'd143, 64'd65025, 64'd0};
`endif

  initial begin
    int le;
    int d1;
    int d2;
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy8", 64'(bus8.busy), 64'd0);
    check("rst_done8", 64'(bus8.done), 64'd0);
    check("rst_prod8", 64'(bus8.product), 64'd0);
    check("rst_prod1", 64'(bus1.product), 64'd0);

    for (int i = 0; i < NV; i++) begin
      start(0, va[i], vb[i], 1'b0, le);
      wait_done(0, le, vp[i], $sformatf("vec%0d", i), d1);
    end

    // load held through RUN with new operands: second op starts only from IDLE
    start(0, 32'd7, 32'd6, 1'b1, le);
    drive(0, 1'b1, 32'd3, 32'd3);
    wait_done(0, le, 64'd42, "hold_a", d1);
    wait_done(0, d1 + 2, 64'd9, "hold_b", d2);
    drive(0, 1'b0, 32'd3, 32'd3);
    check("hold_gap", 64'(d2 - d1), 64'd10);

    // reset during the fourth RUN cycle discards the operation
    start(0, 32'd9, 32'd9, 1'b0, le);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(bus8.busy), 64'd0);
    check("midrst_done", 64'(bus8.done), 64'd0);
    check("midrst_prod", 64'(bus8.product), 64'd0);
    start(0, 32'd2, 32'd5, 1'b0, le);
    wait_done(0, le, 64'd10, "after_rst", d1);

    // single-bit instance
    start(1, 32'd1, 32'd1, 1'b0, le);
    wait_done(1, le, 64'd1, "w1", d1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
